iob_eth_rx_reader: RTL and testbench

- Downstream consumer of the Ethernet receive stage.
- Once a received frame has been written to the RX byte buffer and flagged ready, this block:
  - reads the frame back through the buffer's read port (1-cycle latency);
  - packs the bytes little-endian into 32-bit words;
  - streams the words to the host datapath with a valid/ready handshake;
  - pulses `receive` to release the buffer for the next frame.
- It sits on the system-clock side of the RX buffer.

---
 rtl/iob_eth_rx_reader.sv | 129 ++++++++++++
 tb/tb_iob_eth_rx_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_rx_reader.sv
// Reads a received Ethernet frame out of the RX byte buffer, packs it
// little-endian into 32-bit words and streams them to the host with valid/ready.
module iob_eth_rx_reader #(
  parameter int BUF_AW    = 11,
  parameter int HDR_BYTES = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_ready,
  input  logic [BUF_AW-1:0] nbytes,
  output logic              receive,
  output logic              buf_rd,
  output logic [BUF_AW-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic [31:0]       out_data,
  output logic [3:0]        out_strb,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_OUT     = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  localparam int LW = BUF_AW + 2;

  logic [2:0]        r_state;
  logic [BUF_AW-1:0] r_cnt;
  logic [BUF_AW-1:0] r_last_addr;
  logic [31:0]       r_word;
  logic [3:0]        r_strb;
  logic              r_last;

  logic [1:0]        w_lane;
  logic              w_at_end;
  logic              w_word_done;

  // Frame length saturates at the buffer size so the read address never wraps.
  function automatic logic [BUF_AW-1:0] last_addr(input logic [BUF_AW-1:0] nb);
    logic [LW-1:0] len;
    logic [LW-1:0] lm1;
    len = LW'(HDR_BYTES) + {2'b00, nb};
    if (len > LW'(1 << BUF_AW))
      len = LW'(1 << BUF_AW);
    lm1 = len - 1'b1;
    return lm1[BUF_AW-1:0];
  endfunction

  function automatic logic [3:0] strb_fill(input logic [1:0] lane);
    case (lane)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  assign w_lane      = r_cnt[1:0];
  assign w_at_end    = (r_cnt == r_last_addr);
  assign w_word_done = (w_lane == 2'd3) || w_at_end;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_addr <= '0;
      r_word      <= '0;
      r_strb      <= '0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_last_addr <= last_addr(nbytes);
            r_cnt       <= '0;
            r_word      <= '0;
            r_state     <= S_READ;
          end
        end
        S_READ: r_state <= S_LATCH;
        S_LATCH: begin
          r_word[{w_lane, 3'b000} +: 8] <= buf_data;
          if (w_word_done) begin
            r_strb  <= strb_fill(w_lane);
            r_last  <= w_at_end;
            r_state <= S_OUT;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_READ;
          end
        end
        S_OUT: begin
          // Word, strobe and last hold here until the consumer takes them.
          if (out_ready) begin
            if (r_last) begin
              r_state <= S_RELEASE;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_word  <= '0;
              r_state <= S_READ;
            end
          end
        end
        S_RELEASE: r_state <= S_DRAIN;
        S_DRAIN: begin
          if (!rx_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // buf_addr follows the byte counter, which only moves on the way into READ.
  assign buf_rd    = (r_state == S_READ);
  assign buf_addr  = r_cnt;
  assign out_valid = (r_state == S_OUT);
  assign out_data  = r_word;
  assign out_strb  = r_strb;
  assign out_last  = r_last;
  assign receive   = (r_state == S_RELEASE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_iob_eth_rx_reader.sv
// Scoreboard bench for iob_eth_rx_reader: a frame model fills an expected-word
// queue, a negedge monitor pops it on every handshake and watches buffer reads.
module tb_iob_eth_rx_reader;

  logic        clk;
  logic        rstn;
  logic        rx_ready;
  logic [10:0] nbytes;
  logic        receive;
  logic        buf_rd;
  logic [10:0] buf_addr;
  logic [7:0]  buf_data;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  iob_eth_rx_reader #(.BUF_AW(11), .HDR_BYTES(14)) dut (
    .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .nbytes(nbytes),
    .receive(receive), .buf_rd(buf_rd), .buf_addr(buf_addr), .buf_data(buf_data),
    .out_data(out_data), .out_strb(out_strb), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem[2048];
  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;
  int          rd_base = 0;
  int          rcv_cnt = 0;
  int          mode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RX buffer read port: one cycle of latency.
  always @(posedge clk) begin
    if (buf_rd) buf_data <= mem[buf_addr];
  end

  // Consumer back-pressure: 0 always ready, 1 toggle, 2 random, 3 never ready.
  initial out_ready = 1'b1;
  always begin
    @(posedge clk);
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(input int nb);
    int len;
    len = 14 + nb;
    if (len > 2048) len = 2048;
    return len;
  endfunction

  // Reference model: slice the frame into 4-byte little-endian words.
  function automatic void push_frame(input int nb);
    int   len;
    int   nw;
    exp_t e;
    len = frame_len(nb);
    nw  = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      e = '0;
      for (int i = 0; i < 4; i++) begin
        if (4 * w + i < len) begin
          e.d = e.d | (32'(mem[4 * w + i]) << (8 * i));
          e.s[i] = 1'b1;
        end
      end
      e.l = (w == nw - 1);
      q.push_back(e);
    end
  endfunction

  // Monitor
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;
  logic [3:0]  ps = '0;
  logic        pl = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
    end else begin
      if (buf_rd) begin
        chk("read_addr", 32'(buf_addr), 32'(rd_cnt - rd_base));
        chk("read_during_out", 32'(out_valid), 32'd0);
        rd_cnt++;
      end
      if (receive) rcv_cnt++;
      if (out_valid) begin
        if (pv && !pr) begin
          chk("stall_data", out_data, pd);
          chk("stall_strb", 32'(out_strb), 32'(ps));
          chk("stall_last", 32'(out_last), 32'(pl));
        end
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_word", 32'd1, 32'd0);
          end else begin
            chk("word_data", out_data, q[0].d);
            chk("word_strb", 32'(out_strb), 32'(q[0].s));
            chk("word_last", 32'(out_last), 32'(q[0].l));
            void'(q.pop_front());
          end
        end
        pv = 1'b1;
        pr = out_ready;
        pd = out_data;
        ps = out_strb;
        pl = out_last;
      end else begin
        pv = 1'b0;
      end
    end
  end

  task automatic wait_receive(input int rcv0, input int budget);
    int n;
    n = 0;
    while (rcv_cnt == rcv0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rcv_cnt == rcv0) chk("receive_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_frame(input int rcv0, input int len, input int hold);
    wait_receive(rcv0, 30000);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_no_read", 32'(buf_rd), 32'd0);
    end
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("receive_count", 32'(rcv_cnt - rcv0), 32'd1);
    chk("read_count", 32'(rd_cnt - rd_base), 32'(len));
    chk("words_left", 32'(q.size()), 32'd0);
  endtask

  task automatic run_frame(input int nb, input int md, input bit ramp, input int hold, input int chg);
    int rcv0;
    @(posedge clk); #1;
    for (int k = 0; k < 2048; k++) mem[k] = ramp ? 8'(k) : 8'($urandom);
    push_frame(nb);
    mode     = md;
    rcv0     = rcv_cnt;
    rd_base  = rd_cnt;
    nbytes   = 11'(nb);
    rx_ready = 1'b1;
    if (chg >= 0) begin
      repeat (8) @(posedge clk);
      #1 nbytes = 11'(chg);
    end
    finish_frame(rcv0, frame_len(nb), hold);
  endtask

  task automatic reset_mid_frame();
    int rcv0;
    int n;
    @(posedge clk); #1;
    for (int k = 0; k < 2048; k++) mem[k] = 8'($urandom);
    push_frame(40);
    mode     = 3;
    rcv0     = rcv_cnt;
    rd_base  = rd_cnt;
    nbytes   = 11'd40;
    rx_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_out", 32'(out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_buf_rd", 32'(buf_rd), 32'd0);
    chk("rst_receive", 32'(receive), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    push_frame(40);
    rd_base = rd_cnt;
    mode    = 0;
    rstn    = 1'b1;
    finish_frame(rcv0, frame_len(40), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    rx_ready = 1'b0;
    nbytes   = '0;
    #12;
    chk("reset_receive", 32'(receive), 32'd0);
    chk("reset_buf_rd", 32'(buf_rd), 32'd0);
    chk("reset_buf_addr", 32'(buf_addr), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_strb", 32'(out_strb), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    run_frame(0, 0, 1'b1, 0, -1);
    run_frame(2, 1, 1'b0, 6, -1);
    run_frame(2034, 0, 1'b0, 0, -1);
    run_frame(2047, 2, 1'b0, 0, -1);
    reset_mid_frame();
    run_frame(5, 0, 1'b0, 2, 100);
    run_frame(100, 0, 1'b0, 0, -1);
    for (int i = 0; i < 6; i++)
      run_frame(int'($urandom_range(0, 300)), int'($urandom_range(0, 2)), 1'b0, int'($urandom_range(0, 3)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
